// File: rtl/board_mover.sv
// Player movement engine for the 4x4 board game: moves the player one cell per
// accepted command, collects the prize on the landing cell and reports the move.
module board_mover #(
  parameter logic [3:0]  START_PLACE = 4'd0,
  parameter logic [15:0] PRIZE_MAP   = 16'h0012,
  parameter bit          WRAP        = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] direction,
  input  logic       dir_valid,
  output logic       dir_ready,
  output logic [3:0] new_place,
  output logic [3:0] prize,
  output logic       move_valid,
  output logic       blocked,
  output logic [4:0] remaining,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    REPORT = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

  // The start cell never holds a collectable prize.
  localparam logic [15:0] INIT_PRIZES    = PRIZE_MAP & ~(16'd1 << START_PLACE);
  localparam logic [4:0]  INIT_REMAINING = popcount16(INIT_PRIZES);
  localparam state_t      INIT_STATE     = (INIT_REMAINING == 5'd0) ? DONE : IDLE;

  state_t      state_r;
  state_t      state_n_s;
  logic [1:0]  dir_r;
  logic [15:0] prizes_r;

  logic [1:0]  row_s;
  logic [1:0]  col_s;
  logic [1:0]  row_t_s;
  logic [1:0]  col_t_s;
  logic        edge_s;
  logic        blocked_s;
  logic [3:0]  target_s;
  logic        hit_s;
  logic [3:0]  prize_val_s;

  assign row_s     = new_place[3:2];
  assign col_s     = new_place[1:0];
  assign dir_ready = (state_r == IDLE);

  // Target cell: 2-bit row/col arithmetic wraps modulo 4; clamping overrides it.
  always_comb begin
    row_t_s   = row_s;
    col_t_s   = col_s;
    edge_s    = 1'b0;
    blocked_s = 1'b0;
    target_s  = new_place;
    case (dir_r)
      2'b00: begin
        row_t_s = row_s - 2'd1;
        edge_s  = (row_s == 2'd0);
      end
      2'b01: begin
        col_t_s = col_s + 2'd1;
        edge_s  = (col_s == 2'd3);
      end
      2'b10: begin
        row_t_s = row_s + 2'd1;
        edge_s  = (row_s == 2'd3);
      end
      2'b11: begin
        col_t_s = col_s - 2'd1;
        edge_s  = (col_s == 2'd0);
      end
      default: begin
        row_t_s = row_s;
        col_t_s = col_s;
      end
    endcase
    if (edge_s && !WRAP) begin
      row_t_s   = row_s;
      col_t_s   = col_s;
      blocked_s = 1'b1;
    end else begin
      blocked_s = 1'b0;
    end
    target_s = {row_t_s, col_t_s};
  end

  assign hit_s       = prizes_r[target_s];
  assign prize_val_s = {2'd0, row_t_s} + {2'd0, col_t_s} + 4'd1;

  // Next-state decode.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (dir_valid) begin
          state_n_s = MOVE;
        end else begin
          state_n_s = IDLE;
        end
      end
      MOVE: state_n_s = REPORT;
      REPORT: begin
        if (remaining == 5'd0) begin
          state_n_s = DONE;
        end else begin
          state_n_s = IDLE;
        end
      end
      DONE:    state_n_s = DONE;
      default: state_n_s = IDLE;
    endcase
  end

  // State register and done flag, which follows entry into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= INIT_STATE;
      done    <= (INIT_REMAINING == 5'd0);
    end else begin
      state_r <= state_n_s;
      done    <= (state_n_s == DONE);
    end
  end

  // Command latch: direction is captured only at the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_r <= 2'b00;
    end else if (state_r == IDLE && dir_valid) begin
      dir_r <= direction;
    end
  end

  // Move commit: position, prize bookkeeping and the report strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prizes_r   <= INIT_PRIZES;
      remaining  <= INIT_REMAINING;
      new_place  <= START_PLACE;
      prize      <= 4'd0;
      blocked    <= 1'b0;
      move_valid <= 1'b0;
    end else begin
      move_valid <= (state_r == MOVE);
      if (state_r == MOVE) begin
        new_place <= target_s;
        blocked   <= blocked_s;
        if (hit_s) begin
          prize              <= prize_val_s;
          prizes_r[target_s] <= 1'b0;
          remaining          <= remaining - 5'd1;
        end else begin
          prize <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_board_mover.sv
// Scoreboard bench for board_mover: a clamping and a wrapping instance on one clock.
module tb_board_mover;

  typedef struct packed {
    logic [3:0] place;
    logic [3:0] prize;
    logic       blocked;
    logic [4:0] remaining;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] dir0 = 2'b00, dir1 = 2'b00;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic       rdy0, rdy1, mv0, mv1, blk0, blk1, done0, done1;
  logic [3:0] pl0, pl1, pz0, pz1;
  logic [4:0] rem0, rem1;

  int n_checks = 0;
  int n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  board_mover #(.WRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .direction(dir0), .dir_valid(v0), .dir_ready(rdy0),
    .new_place(pl0), .prize(pz0), .move_valid(mv0), .blocked(blk0),
    .remaining(rem0), .done(done0)
  );

  board_mover #(.WRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .direction(dir1), .dir_valid(v1), .dir_ready(rdy1),
    .new_place(pl1), .prize(pz1), .move_valid(mv1), .blocked(blk1),
    .remaining(rem1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Report monitors pop the scoreboard on every move_valid strobe.
  always @(negedge clk) begin
    if (mv0) begin
      if (q0.size() == 0) begin
        check("unexpected_mv0", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        check("place0", {28'd0, pl0}, {28'd0, e0.place});
        check("prize0", {28'd0, pz0}, {28'd0, e0.prize});
        check("blocked0", {31'd0, blk0}, {31'd0, e0.blocked});
        check("remaining0", {27'd0, rem0}, {27'd0, e0.remaining});
      end
    end
    if (mv1) begin
      if (q1.size() == 0) begin
        check("unexpected_mv1", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("place1", {28'd0, pl1}, {28'd0, e1.place});
        check("prize1", {28'd0, pz1}, {28'd0, e1.prize});
        check("blocked1", {31'd0, blk1}, {31'd0, e1.blocked});
        check("remaining1", {27'd0, rem1}, {27'd0, e1.remaining});
      end
    end
  end

  task automatic send(input int inst, input logic [1:0] d, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!((inst == 0) ? rdy0 : rdy1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!((inst == 0) ? rdy0 : rdy1)) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    if (inst == 0) begin q0.push_back(e); dir0 = d; v0 = 1'b1; end
    else           begin q1.push_back(e); dir1 = d; v1 = 1'b1; end
    @(negedge clk);
    // Drop valid and scramble direction while the move is in flight.
    if (inst == 0) begin v0 = 1'b0; dir0 = ~d; end
    else           begin v1 = 1'b0; dir1 = ~d; end
    check("ready_in_move", {31'd0, (inst == 0) ? rdy0 : rdy1}, 32'd0);
    check("mv_early", {31'd0, (inst == 0) ? mv0 : mv1}, 32'd0);
    @(negedge clk);
    check("mv_latency", {31'd0, (inst == 0) ? mv0 : mv1}, 32'd1);
    @(negedge clk);
    check("mv_one_cycle", {31'd0, (inst == 0) ? mv0 : mv1}, 32'd0);
    check("hold_place", {28'd0, (inst == 0) ? pl0 : pl1}, {28'd0, e.place});
  endtask

  initial begin
    #12;
    check("rst_place", {28'd0, pl0}, 32'd0);
    check("rst_remaining", {27'd0, rem0}, 32'd2);
    check("rst_ready", {31'd0, rdy0}, 32'd1);
    check("rst_mv", {31'd0, mv0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_place", {28'd0, pl0}, 32'd0);
    check("post_rst_remaining", {27'd0, rem0}, 32'd2);
    check("post_rst_ready", {31'd0, rdy0}, 32'd1);

    // Collect right, then clamp tests.
    send(0, 2'b01, '{place: 4'd1, prize: 4'd2, blocked: 1'b0, remaining: 5'd1});
    check("ready_after_report", {31'd0, rdy0}, 32'd1);
    send(0, 2'b11, '{place: 4'd0, prize: 4'd0, blocked: 1'b0, remaining: 5'd1});
    send(0, 2'b00, '{place: 4'd0, prize: 4'd0, blocked: 1'b1, remaining: 5'd1});

    // Wrapping instance: left off column 0, then down, then up off row 0.
    send(1, 2'b11, '{place: 4'd3, prize: 4'd0, blocked: 1'b0, remaining: 5'd2});
    send(1, 2'b10, '{place: 4'd7, prize: 4'd0, blocked: 1'b0, remaining: 5'd2});
    send(1, 2'b00, '{place: 4'd3, prize: 4'd0, blocked: 1'b0, remaining: 5'd2});
    send(1, 2'b00, '{place: 4'd15, prize: 4'd0, blocked: 1'b0, remaining: 5'd2});

    // Clear the board and confirm the lock.
    send(0, 2'b10, '{place: 4'd4, prize: 4'd2, blocked: 1'b0, remaining: 5'd0});
    check("done_set", {31'd0, done0}, 32'd1);
    check("done_ready", {31'd0, rdy0}, 32'd0);
    dir0 = 2'b01;
    v0 = 1'b1;
    repeat (10) @(negedge clk);
    v0 = 1'b0;
    check("done_hold", {31'd0, done0}, 32'd1);
    check("done_place_hold", {28'd0, pl0}, 32'd4);

    // Abort a move in flight with reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rerst_remaining", {27'd0, rem0}, 32'd2);
    dir0 = 2'b01;
    v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    check("abort_in_move", {31'd0, rdy0}, 32'd0);
    reset = 1'b1;
    #1;
    check("abort_async_ready", {31'd0, rdy0}, 32'd1);
    check("abort_async_mv", {31'd0, mv0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_place", {28'd0, pl0}, 32'd0);
    check("abort_remaining", {27'd0, rem0}, 32'd2);
    check("abort_ready", {31'd0, rdy0}, 32'd1);
    check("abort_done", {31'd0, done0}, 32'd0);

    check("sb_empty0", q0.size(), 32'd0);
    check("sb_empty1", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_mover.md
# board_mover

Player movement engine for the 4x4 board game, and the producer of the `new_place`/`prize` stream that the earned-prizes accumulator consumes. It accepts one direction command at a time over a valid/ready handshake and moves the player on the 4x4 grid. It looks up and consumes the prize on the landing cell, then emits a one-cycle move report. It tracks the number of prizes left and locks once the board is cleared.

## Interface
- `START_PLACE`, default 4'd0: cell the player occupies after reset. The prize bit on this cell is ignored.
- `PRIZE_MAP`, default 16'h0012: bit i set means cell i holds a prize at reset.
- `WRAP`, default 0: 0 means a move off an edge is blocked (clamp); 1 means the move wraps to the opposite edge of the same row or column.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous reset, active-high.
- `direction`  in  2  move command: 00 up (row-1), 01 right (col+1), 10 down (row+1), 11 left (col-1).
- `dir_valid`  in  1  `direction` holds a valid command.
- `dir_ready`  out  1  block can accept a command.
- `new_place`  out  4  current player cell, encoded row*4+col (row = [3:2], col = [1:0]).
- `prize`  out  4  prize collected by the reported move; 0 if none.
- `move_valid`  out  1  one-cycle strobe; `new_place`, `prize` and `blocked` are valid for this move.
- `blocked`  out  1  reported move hit an edge (WRAP=0 only); the position is unchanged.
- `remaining`  out  5  prizes still on the board.
- `done`  out  1  all prizes collected.

## Operation
- States: IDLE, MOVE, REPORT, DONE.
- **Reset state:** state = IDLE, or DONE if the initial `remaining` is 0.
- **Reset contents:**
  - prize register = PRIZE_MAP with bit START_PLACE cleared.
  - `remaining` = popcount of that register.
  - `new_place` = START_PLACE.
  - `prize`, `move_valid`, `blocked` = 0.
  - `done` = (remaining == 0).
- **IDLE:** `dir_ready` = 1. On `dir_valid && dir_ready`, latch `direction` and go to MOVE.
- **MOVE:** `dir_ready` = 0. Compute the target cell.
  - WRAP=0, edge crossed: target = current cell, blocked = 1.
  - WRAP=1: row/col arithmetic is modulo 4, and blocked is always 0.
- **MOVE to REPORT (at the edge):**
  - `new_place` <= target.
  - If the target's prize bit is set: `prize` <= 1 + row + col (range 1..7), the bit is cleared, and `remaining` is decremented. Otherwise `prize` <= 0.
  - `move_valid` <= 1.
- **Blocked move:** lands on the current cell, whose bit is already clear, so `prize` = 0.
- **REPORT:** `move_valid` is high for exactly this cycle. Next state is DONE if `remaining` == 0, else IDLE.
- **DONE:**
  - `dir_ready` = 0 and `done` = 1.
  - `dir_valid` is ignored.
  - Exit only via `reset`.
- `prize`, `blocked` and `new_place` hold their values after `move_valid` falls, until the next report.
- `direction` is sampled only at the accepting edge; later changes do not affect the move in flight.

## Timing
- **Accept:** at rising edge k with IDLE and `dir_valid`=1.
- **Report:** `move_valid` = 1 in the cycle following edge k+1. `new_place`/`prize`/`remaining` update at edge k+1.
- **Return to IDLE:** edge k+2, with `dir_ready` = 1 again in that cycle. Maximum throughput is one command per 3 cycles.
- **`dir_ready`:** decoded from state (IDLE only), not registered separately.
- **`done`:** rises at edge k+2 of the move that collects the last prize. `dir_ready` stays 0 from then on.
- **Reset during MOVE or REPORT:** the move is aborted and no `move_valid` is produced. All outputs take their reset values asynchronously.
- **Held `dir_valid`:** held continuously, it is accepted again at each return to IDLE (every 3 cycles).

## Test plan
- **Reset:** defaults, `reset`=1 then 0 → `new_place`=0, `remaining`=2, `dir_ready`=1, `move_valid`=0, `done`=0.
- **Collect right:** from cell 0, `direction`=01 accepted at edge k → `move_valid`=1 after edge k+1 with `new_place`=1, `prize`=2, `remaining`=1, `blocked`=0. `dir_ready`=1 after edge k+2.
- **Clamp:** from cell 1, `direction`=11 → `new_place`=0, `prize`=0. Then `direction`=00 → `new_place`=0, `blocked`=1, `prize`=0, `remaining`=1.
- **Clear board:** from cell 0, `direction`=10 → `new_place`=4, `prize`=2, `remaining`=0. After edge k+2, `done`=1 and `dir_ready`=0. `dir_valid` held 10 cycles → no further `move_valid`.
- **Wrap:** WRAP=1, from 0, `direction`=11 → `new_place`=3, `blocked`=0. Then `direction`=10 → `new_place`=7.
- **Abort:** `reset` pulsed during MOVE → no `move_valid`. `new_place`=0, `remaining`=2, `dir_ready`=1 after release.
